// File: rtl/vtc_multimode.sv
// vtc_multimode
// Video timing controller with two compile-time timing modes selectable at
// runtime. Counters advance every pixel clock; HS/VS/active are derived from
// the counters, given the sync polarity of the mode that produced them, and
// delayed through a PIPE_DELAY-deep register chain. The delay keeps them
// aligned with a pipelined pattern generator.
//
// Ports
//   clock       pixel clock
//   rst         asynchronous active-high reset
//   modeSel     requested mode, taken only on the last pixel of a frame
//   hPixel      horizontal counter (undelayed)
//   vLine       vertical counter (undelayed)
//   hSync       horizontal sync, delayed PIPE_DELAY cycles
//   vSync       vertical sync, delayed PIPE_DELAY cycles
//   vActive     active-area flag, delayed PIPE_DELAY cycles
//   frameStart  high while the counters sit at (0,0) and rst is low
//   activeMode  mode currently being generated
//   frameCount  completed frames, wraps 65535 -> 0
module vtc_multimode #(
    parameter int CNT_W      = 11,
    parameter int PIPE_DELAY = 2,
    parameter int H_AREA0    = 640,
    parameter int H_FP0      = 16,
    parameter int H_SYNC0    = 96,
    parameter int H_BP0      = 48,
    parameter int V_AREA0    = 480,
    parameter int V_FP0      = 10,
    parameter int V_SYNC0    = 2,
    parameter int V_BP0      = 33,
    parameter bit H_POL0     = 1'b0,
    parameter bit V_POL0     = 1'b0,
    parameter int H_AREA1    = 800,
    parameter int H_FP1      = 40,
    parameter int H_SYNC1    = 128,
    parameter int H_BP1      = 88,
    parameter int V_AREA1    = 600,
    parameter int V_FP1      = 1,
    parameter int V_SYNC1    = 4,
    parameter int V_BP1      = 23,
    parameter bit H_POL1     = 1'b1,
    parameter bit V_POL1     = 1'b1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             modeSel,
    output logic [CNT_W-1:0] hPixel,
    output logic [CNT_W-1:0] vLine,
    output logic             hSync,
    output logic             vSync,
    output logic             vActive,
    output logic             frameStart,
    output logic             activeMode,
    output logic [15:0]      frameCount
);

    // Per-mode decode points: last count, end of active area, sync window.
    localparam logic [CNT_W-1:0] H_LAST0 = CNT_W'(H_AREA0 + H_FP0 + H_SYNC0 + H_BP0 - 1);
    localparam logic [CNT_W-1:0] H_ACT0  = CNT_W'(H_AREA0);
    localparam logic [CNT_W-1:0] H_SS0   = CNT_W'(H_AREA0 + H_FP0);
    localparam logic [CNT_W-1:0] H_SE0   = CNT_W'(H_AREA0 + H_FP0 + H_SYNC0);
    localparam logic [CNT_W-1:0] V_LAST0 = CNT_W'(V_AREA0 + V_FP0 + V_SYNC0 + V_BP0 - 1);
    localparam logic [CNT_W-1:0] V_ACT0  = CNT_W'(V_AREA0);
    localparam logic [CNT_W-1:0] V_SS0   = CNT_W'(V_AREA0 + V_FP0);
    localparam logic [CNT_W-1:0] V_SE0   = CNT_W'(V_AREA0 + V_FP0 + V_SYNC0);
    localparam logic [CNT_W-1:0] H_LAST1 = CNT_W'(H_AREA1 + H_FP1 + H_SYNC1 + H_BP1 - 1);
    localparam logic [CNT_W-1:0] H_ACT1  = CNT_W'(H_AREA1);
    localparam logic [CNT_W-1:0] H_SS1   = CNT_W'(H_AREA1 + H_FP1);
    localparam logic [CNT_W-1:0] H_SE1   = CNT_W'(H_AREA1 + H_FP1 + H_SYNC1);
    localparam logic [CNT_W-1:0] V_LAST1 = CNT_W'(V_AREA1 + V_FP1 + V_SYNC1 + V_BP1 - 1);
    localparam logic [CNT_W-1:0] V_ACT1  = CNT_W'(V_AREA1);
    localparam logic [CNT_W-1:0] V_SS1   = CNT_W'(V_AREA1 + V_FP1);
    localparam logic [CNT_W-1:0] V_SE1   = CNT_W'(V_AREA1 + V_FP1 + V_SYNC1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pipeline stage layout is {active, vs, hs}; idle is the mode-0 inactive level.
    localparam logic [2:0] STAGE_IDLE = {1'b0, ~V_POL0, ~H_POL0};

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             active_mode_r;
    logic [15:0]      frame_count_r;
    logic [PIPE_DELAY-1:0][2:0] sync_pipe_r;
    logic [PIPE_DELAY-1:0][2:0] sync_pipe_next_s;

    logic [CNT_W-1:0] h_last_s, h_act_s, h_ss_s, h_se_s;
    logic [CNT_W-1:0] v_last_s, v_act_s, v_ss_s, v_se_s;
    logic             h_pol_s, v_pol_s;
    logic             h_end_s, v_end_s;
    logic             hs_on_s, vs_on_s;
    logic [2:0]       raw_stage_s;

    // Select the decode points of the mode being generated.
    always_comb begin
        h_last_s = H_LAST0;
        h_act_s  = H_ACT0;
        h_ss_s   = H_SS0;
        h_se_s   = H_SE0;
        v_last_s = V_LAST0;
        v_act_s  = V_ACT0;
        v_ss_s   = V_SS0;
        v_se_s   = V_SE0;
        h_pol_s  = H_POL0;
        v_pol_s  = V_POL0;
        if (active_mode_r) begin
            h_last_s = H_LAST1;
            h_act_s  = H_ACT1;
            h_ss_s   = H_SS1;
            h_se_s   = H_SE1;
            v_last_s = V_LAST1;
            v_act_s  = V_ACT1;
            v_ss_s   = V_SS1;
            v_se_s   = V_SE1;
            h_pol_s  = H_POL1;
            v_pol_s  = V_POL1;
        end else begin
            h_last_s = H_LAST0;
            h_act_s  = H_ACT0;
            h_ss_s   = H_SS0;
            h_se_s   = H_SE0;
            v_last_s = V_LAST0;
            v_act_s  = V_ACT0;
            v_ss_s   = V_SS0;
            v_se_s   = V_SE0;
            h_pol_s  = H_POL0;
            v_pol_s  = V_POL0;
        end
    end

    assign h_end_s = (h_cnt_r == h_last_s);
    assign v_end_s = (v_cnt_r == v_last_s);
    assign hs_on_s = (h_cnt_r >= h_ss_s) && (h_cnt_r < h_se_s);
    assign vs_on_s = (v_cnt_r >= v_ss_s) && (v_cnt_r < v_se_s);

    // Polarity is applied here so delayed samples keep their own mode's level.
    always_comb begin
        raw_stage_s[0] = hs_on_s ? h_pol_s : ~h_pol_s;
        raw_stage_s[1] = vs_on_s ? v_pol_s : ~v_pol_s;
        raw_stage_s[2] = (h_cnt_r < h_act_s) && (v_cnt_r < v_act_s);
    end

    // Shift the delay chain by one stage, newest sample entering at index 0.
    always_comb begin
        sync_pipe_next_s = sync_pipe_r;
        for (int i = PIPE_DELAY - 1; i > 0; i--) begin
            sync_pipe_next_s[i] = sync_pipe_r[i-1];
        end
        sync_pipe_next_s[0] = raw_stage_s;
    end

    // Pixel/line counters; mode and frame count change only on the frame wrap,
    // so a frame in progress never mixes timings.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            h_cnt_r       <= '0;
            v_cnt_r       <= '0;
            active_mode_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (h_end_s) begin
            h_cnt_r <= '0;
            if (v_end_s) begin
                v_cnt_r       <= '0;
                active_mode_r <= modeSel;
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                v_cnt_r <= v_cnt_r + CNT_ONE;
            end
        end else begin
            h_cnt_r <= h_cnt_r + CNT_ONE;
        end
    end

    // Sync/active delay chain; reset fills every stage with the idle level.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_pipe_r <= {PIPE_DELAY{STAGE_IDLE}};
        end else begin
            sync_pipe_r <= sync_pipe_next_s;
        end
    end

    assign hPixel     = h_cnt_r;
    assign vLine      = v_cnt_r;
    assign activeMode = active_mode_r;
    assign frameCount = frame_count_r;
    assign hSync      = sync_pipe_r[PIPE_DELAY-1][0];
    assign vSync      = sync_pipe_r[PIPE_DELAY-1][1];
    assign vActive    = sync_pipe_r[PIPE_DELAY-1][2];
    // Counters already sit at (0,0) during reset, so the pulse is gated by rst.
    assign frameStart = ~rst && (h_cnt_r == '0) && (v_cnt_r == '0);

endmodule

// File: tb/tb_vtc_multimode.sv
module tb_vtc_multimode;

    localparam int CW = 11;
    localparam int NI = 4;
    // Shrunken timings keep whole frames short (mode 0: 15x10, mode 1: 16x10).
    localparam int HA0 = 8,  HF0 = 2, HS0 = 3, HB0 = 2, VA0 = 6, VF0 = 1, VS0 = 2, VB0 = 1;
    localparam int HA1 = 10, HF1 = 1, HS1 = 2, HB1 = 3, VA1 = 5, VF1 = 2, VS1 = 1, VB1 = 2;

    logic clock = 1'b0;
    logic rst, rst_w, modeSel;
    logic [NI-1:0][CW-1:0] hp_w, vl_w;
    logic [NI-1:0]         hs_w, vs_w, va_w, fs_w, am_w;
    logic [NI-1:0][15:0]   fc_w;

    always #5 clock = ~clock;

    // Instances 0..2 share timings with delays 2, 1 and 8.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        vtc_multimode #(
            .CNT_W(CW), .PIPE_DELAY(g == 0 ? 2 : (g == 1 ? 1 : 8)),
            .H_AREA0(HA0), .H_FP0(HF0), .H_SYNC0(HS0), .H_BP0(HB0),
            .V_AREA0(VA0), .V_FP0(VF0), .V_SYNC0(VS0), .V_BP0(VB0),
            .H_POL0(1'b0), .V_POL0(1'b0),
            .H_AREA1(HA1), .H_FP1(HF1), .H_SYNC1(HS1), .H_BP1(HB1),
            .V_AREA1(VA1), .V_FP1(VF1), .V_SYNC1(VS1), .V_BP1(VB1),
            .H_POL1(1'b1), .V_POL1(1'b1)
        ) dut (
            .clock(clock), .rst(rst), .modeSel(modeSel),
            .hPixel(hp_w[g]), .vLine(vl_w[g]), .hSync(hs_w[g]), .vSync(vs_w[g]),
            .vActive(va_w[g]), .frameStart(fs_w[g]), .activeMode(am_w[g]),
            .frameCount(fc_w[g])
        );
    end

    // One-pixel frames: frameCount advances every clock, reaching the wrap quickly.
    vtc_multimode #(
        .CNT_W(CW), .PIPE_DELAY(2),
        .H_AREA0(1), .H_FP0(0), .H_SYNC0(0), .H_BP0(0),
        .V_AREA0(1), .V_FP0(0), .V_SYNC0(0), .V_BP0(0),
        .H_POL0(1'b0), .V_POL0(1'b0),
        .H_AREA1(1), .H_FP1(0), .H_SYNC1(0), .H_BP1(0),
        .V_AREA1(1), .V_FP1(0), .V_SYNC1(0), .V_BP1(0),
        .H_POL1(1'b1), .V_POL1(1'b1)
    ) dut_wrap (
        .clock(clock), .rst(rst_w), .modeSel(modeSel),
        .hPixel(hp_w[3]), .vLine(vl_w[3]), .hSync(hs_w[3]), .vSync(vs_w[3]),
        .vActive(va_w[3]), .frameStart(fs_w[3]), .activeMode(am_w[3]),
        .frameCount(fc_w[3])
    );

    // ---------------- reference model ----------------
    int  tim [NI][2][8];     // H area,fp,sync,bp then V area,fp,sync,bp
    bit  pol [NI][2][2];     // [mode][0]=H, [1]=V
    int  dly [NI];
    int  m_pos [NI];         // pixel position inside the current frame
    bit  m_mode [NI];
    bit [15:0] m_fc [NI];
    bit [2:0]  hist [NI][8]; // hist[k][0] = newest raw {act,vs,hs}
    logic rst_edge [NI];
    logic ms_edge;
    int  vectors = 0;
    int  miscompares = 0;
    int  gs = 0;

    task automatic set_tim(input int k, input int m, input int a, input int b, input int c,
                           input int d, input int e, input int f, input int g, input int h);
        tim[k][m][0] = a; tim[k][m][1] = b; tim[k][m][2] = c; tim[k][m][3] = d;
        tim[k][m][4] = e; tim[k][m][5] = f; tim[k][m][6] = g; tim[k][m][7] = h;
    endtask

    function automatic int h_tot(input int k, input bit m);
        return tim[k][m][0] + tim[k][m][1] + tim[k][m][2] + tim[k][m][3];
    endfunction

    function automatic int v_tot(input int k, input bit m);
        return tim[k][m][4] + tim[k][m][5] + tim[k][m][6] + tim[k][m][7];
    endfunction

    function automatic bit [2:0] raw_of(input int k, input int h, input int v, input bit m);
        int ha, hsb, va, vsb;
        bit hs_on, vs_on;
        ha  = tim[k][m][0];
        hsb = ha + tim[k][m][1];
        va  = tim[k][m][4];
        vsb = va + tim[k][m][5];
        hs_on = (h >= hsb) && (h < hsb + tim[k][m][2]);
        vs_on = (v >= vsb) && (v < vsb + tim[k][m][6]);
        return {(h < ha) && (v < va),
                vs_on ? pol[k][m][1] : !pol[k][m][1],
                hs_on ? pol[k][m][0] : !pol[k][m][0]};
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", name, k, got, exp, $time);
        end
    endtask

    // Capture the inputs each DUT sees at the active edge.
    always @(posedge clock) begin
        rst_edge[0] <= rst;
        rst_edge[1] <= rst;
        rst_edge[2] <= rst;
        rst_edge[3] <= rst_w;
        ms_edge     <= modeSel;
    end

    // Advance the model for the edge just passed, then compare every output.
    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            logic r_now;
            int ht, h, v;
            bit [2:0] exp_s;
            r_now = (k == 3) ? rst_w : rst;
            if (r_now || rst_edge[k] !== 1'b0) begin
                m_pos[k]  = 0;
                m_mode[k] = 1'b0;
                m_fc[k]   = 16'd0;
                for (int i = 0; i < 8; i++)
                    hist[k][i] = {1'b0, !pol[k][0][1], !pol[k][0][0]};
            end else begin
                ht = h_tot(k, m_mode[k]);
                for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = raw_of(k, m_pos[k] % ht, m_pos[k] / ht, m_mode[k]);
                m_pos[k]++;
                if (m_pos[k] == ht * v_tot(k, m_mode[k])) begin
                    m_pos[k]  = 0;
                    m_mode[k] = ms_edge;
                    m_fc[k]   = m_fc[k] + 16'd1;
                end
            end
            ht = h_tot(k, m_mode[k]);
            h = m_pos[k] % ht;
            v = m_pos[k] / ht;
            exp_s = hist[k][dly[k]-1];
            check("hPixel",     k, hp_w[k], h);
            check("vLine",      k, vl_w[k], v);
            check("hSync",      k, hs_w[k], exp_s[0]);
            check("vSync",      k, vs_w[k], exp_s[1]);
            check("vActive",    k, va_w[k], exp_s[2]);
            check("frameStart", k, fs_w[k], (h == 0) && (v == 0) && !r_now);
            check("activeMode", k, am_w[k], m_mode[k]);
            check("frameCount", k, fc_w[k], m_fc[k]);
        end
    end

    task automatic step();
        @(negedge clock);
        #2;
        gs++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        for (int k = 0; k < 3; k++) begin
            set_tim(k, 0, HA0, HF0, HS0, HB0, VA0, VF0, VS0, VB0);
            set_tim(k, 1, HA1, HF1, HS1, HB1, VA1, VF1, VS1, VB1);
        end
        set_tim(3, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        set_tim(3, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < NI; k++) begin
            pol[k][0][0] = 1'b0; pol[k][0][1] = 1'b0;
            pol[k][1][0] = 1'b1; pol[k][1][1] = 1'b1;
        end
        dly[0] = 2; dly[1] = 1; dly[2] = 8; dly[3] = 2;

        rst = 1'b1; rst_w = 1'b1; modeSel = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check("lit_rst_hsync", 0, hs_w[0], 1);
        check("lit_rst_vsync", 0, vs_w[0], 1);
        check("lit_rst_vact",  2, va_w[2], 0);
        check("lit_rst_fs",    0, fs_w[0], 0);
        rst = 1'b0; rst_w = 1'b0;
        #1;
        check("lit_rel_fs",   0, fs_w[0], 1);
        check("lit_rel_fs_w", 3, fs_w[3], 1);

        // Frame 1, mode 0: pin edge positions by hand.
        for (int s = 1; s <= 150; s++) begin
            step();
            if (s == 1)   check("lit_va_d1_on",  1, va_w[1], 1);
            if (s == 1)   check("lit_va_d2_off", 0, va_w[0], 0);
            if (s == 2)   check("lit_va_d2_on",  0, va_w[0], 1);
            if (s == 7)   check("lit_va_d8_off", 2, va_w[2], 0);
            if (s == 8)   check("lit_va_d8_on",  2, va_w[2], 1);
            if (s == 10)  check("lit_va_d2_end", 0, va_w[0], 0);
            if (s == 11)  check("lit_hs_pre",    0, hs_w[0], 1);
            if (s == 12)  check("lit_hs_first",  0, hs_w[0], 0);
            if (s == 14)  check("lit_hs_last",   0, hs_w[0], 0);
            if (s == 15)  check("lit_hs_post",   0, hs_w[0], 1);
            if (s == 92)  check("lit_va_line6",  0, va_w[0], 0);
            if (s == 106) check("lit_vs_pre",    0, vs_w[0], 1);
            if (s == 107) check("lit_vs_first",  0, vs_w[0], 0);
            if (s == 137) check("lit_vs_post",   0, vs_w[0], 1);
            if (s == 149) check("lit_fs_149",    0, fs_w[0], 0);
        end
        check("lit_fc1",  0, fc_w[0], 1);
        check("lit_fs150", 0, fs_w[0], 1);

        // Frame 2: modeSel toggled mid-frame must not take effect.
        for (int s = 1; s <= 150; s++) begin
            step();
            if (s == 45) modeSel = 1'b1;
            if (s == 90) modeSel = 1'b0;
        end
        check("lit_fc2",   0, fc_w[0], 2);
        check("lit_mode2", 0, am_w[0], 0);

        // Frame 3: modeSel=1 held through the frame end.
        for (int s = 1; s <= 150; s++) begin
            step();
            if (s == 10) modeSel = 1'b1;
        end
        check("lit_mode3", 0, am_w[0], 1);
        for (int s = 1; s <= 160; s++) begin
            step();
            if (s == 12) check("lit_m1_hs_pre",   0, hs_w[0], 0);
            if (s == 13) check("lit_m1_hs_first", 0, hs_w[0], 1);
            if (s == 15) check("lit_m1_hs_post",  0, hs_w[0], 0);
        end
        check("lit_fc4", 0, fc_w[0], 4);

        // Random mode requests.
        repeat (700) begin
            step();
            modeSel = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset in mid-frame.
        modeSel = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (hp_w[0] == 11'd7 && vl_w[0] == 11'd4) found = 1'b1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL wait_midframe timed out waiting for (7,4)");
        end
        rst = 1'b1;
        #1;
        check("lit_arst_h",  0, hp_w[0], 0);
        check("lit_arst_v",  0, vl_w[0], 0);
        check("lit_arst_fc", 0, fc_w[0], 0);
        check("lit_arst_am", 0, am_w[0], 0);
        check("lit_arst_hs", 0, hs_w[0], 1);
        check("lit_arst_vs", 0, vs_w[0], 1);
        check("lit_arst_va", 2, va_w[2], 0);
        check("lit_arst_fs", 0, fs_w[0], 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("lit_rerel_fs", 0, fs_w[0], 1);
        for (int s = 1; s <= 150; s++) begin
            step();
            if (s == 149) check("lit_refc0", 0, fc_w[0], 0);
        end
        check("lit_refc1", 0, fc_w[0], 1);

        // Run the one-pixel-frame instance up to its frame counter wrap.
        while (gs < 65535) begin
            step();
            modeSel = 1'($urandom_range(0, 1));
        end
        check("lit_fc_ffff", 3, fc_w[3], 16'hFFFF);
        step();
        check("lit_fc_wrap", 3, fc_w[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
